// File: rtl/br_resolver.sv
// br_resolver: resolving end of the branch-prediction interface.
//
// Fetch pushes one prediction per fetched instruction into an in-order
// circular queue. Execute retires instructions in the same order; the
// instruction at the head of the queue is compared against the actual
// outcome. From that comparison the block produces:
//   - a one-cycle predictor update strobe with its bundle,
//   - a one-cycle front-end redirect on mispredict,
//   - saturating branch and mispredict counters,
//   - a sticky protocol error flag.
//
// Ports:
//   clock, reset              single clock, synchronous active-low reset
//   io_fetch_*                push side (valid/pc/prediction), ready out
//   io_exe_*                  resolve side (valid/pc/is_br/type/taken/target)
//   io_br_info_*              registered predictor update bundle
//   io_redirect_valid/pc      registered front-end flush and restart PC
//   io_err                    sticky protocol error
//   io_br_cnt, io_mis_cnt     saturating statistics counters
module br_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_fetch_valid,
  input  logic [63:0]      io_fetch_pc,
  input  logic             io_fetch_pre_valid,
  input  logic [63:0]      io_fetch_pre_next_pc,
  output logic             io_fetch_ready,
  input  logic             io_exe_valid,
  input  logic [63:0]      io_exe_pc,
  input  logic             io_exe_is_br,
  input  logic [1:0]       io_exe_br_type,
  input  logic             io_exe_taken,
  input  logic [63:0]      io_exe_target,
  output logic             io_br_info_valid,
  output logic             io_br_info_mispredict,
  output logic [63:0]      io_br_info_br_pc,
  output logic             io_br_info_taken,
  output logic [63:0]      io_br_info_target_next_pc,
  output logic [1:0]       io_br_info_br_type,
  output logic             io_redirect_valid,
  output logic [63:0]      io_redirect_pc,
  output logic             io_err,
  output logic [CNT_W-1:0] io_br_cnt,
  output logic [CNT_W-1:0] io_mis_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [63:0]      q_pc          [DEPTH];
  logic [63:0]      q_pre_next_pc [DEPTH];
  logic [DEPTH-1:0] q_pre_valid;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;

  logic        empty;
  logic        full;
  logic        push;
  logic        resolve;
  logic        mis;
  logic        err_event;
  logic [63:0] act_next;
  logic [63:0] pred_next;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);

  // Fetch is held off during the redirect cycle so nothing from the
  // squashed path can slip into the freshly cleared queue.
  assign io_fetch_ready = !full && !io_redirect_valid;
  assign push           = io_fetch_valid && io_fetch_ready;
  assign resolve        = io_exe_valid && !empty;

  assign act_next  = io_exe_taken ? io_exe_target : (io_exe_pc + 64'd4);
  assign pred_next = q_pre_valid[head_idx] ? q_pre_next_pc[head_idx]
                                           : (q_pc[head_idx] + 64'd4);
  assign mis       = resolve && (act_next != pred_next);

  // Resolving with an empty queue, or a PC that disagrees with the head,
  // means fetch and execute lost lockstep.
  assign err_event = (io_exe_valid && empty) ||
                     (resolve && (io_exe_pc != q_pc[head_idx]));

  // Entry storage needs no reset: only the pointers define validity.
  // A push coinciding with a mispredict is discarded along with the queue.
  always_ff @(posedge clock) begin
    if (reset && push && !mis) begin
      q_pc[tail_idx]          <= io_fetch_pc;
      q_pre_valid[tail_idx]   <= io_fetch_pre_valid;
      q_pre_next_pc[tail_idx] <= io_fetch_pre_next_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head                      <= '0;
      tail                      <= '0;
      io_br_info_valid          <= 1'b0;
      io_br_info_mispredict     <= 1'b0;
      io_br_info_br_pc          <= '0;
      io_br_info_taken          <= 1'b0;
      io_br_info_target_next_pc <= '0;
      io_br_info_br_type        <= '0;
      io_redirect_valid         <= 1'b0;
      io_redirect_pc            <= '0;
      io_err                    <= 1'b0;
      io_br_cnt                 <= '0;
      io_mis_cnt                <= '0;
    end else begin
      // A non-branch that was predicted taken still has to train the
      // predictor, hence the update also fires on any mispredict.
      io_br_info_valid      <= resolve && (io_exe_is_br || mis);
      io_br_info_mispredict <= mis;
      io_redirect_valid     <= mis;

      if (resolve) begin
        io_br_info_br_pc          <= io_exe_pc;
        io_br_info_taken          <= io_exe_taken && io_exe_is_br;
        io_br_info_target_next_pc <= act_next;
        io_br_info_br_type        <= io_exe_br_type;
        io_redirect_pc            <= act_next;
      end

      if (err_event) begin
        io_err <= 1'b1;
      end

      if (resolve && io_exe_is_br && (io_br_cnt != '1)) begin
        io_br_cnt <= io_br_cnt + CNT_W'(1);
      end
      if (mis && (io_mis_cnt != '1)) begin
        io_mis_cnt <= io_mis_cnt + CNT_W'(1);
      end

      if (mis) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (resolve) begin
          head <= head + PTR_W'(1);
        end
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/br_resolver.md
Name: br_resolver

Overview:
- Resolving end of the branch-prediction interface; sits between fetch and execute.
- Fetch pushes each fetched instruction's prediction (pc, pre_valid, pre_next_pc) into an in-order queue.
- Execute retires instructions in order. The block compares actual next PC against the queued prediction, then:
  - drives the predictor update bundle (io_br_info_*);
  - drives the front-end redirect;
  - keeps branch/mispredict counters.

Parameters:
DEPTH, 4, prediction-queue entries (power of 2, >=2)
CNT_W, 32, width of statistics counters

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clock)
io_fetch_valid  in  1  fetch pushes one entry
io_fetch_pc  in  64  fetched instruction PC
io_fetch_pre_valid  in  1  predictor predicted taken
io_fetch_pre_next_pc  in  64  predicted target
io_fetch_ready  out  1  queue can accept push
io_exe_valid  in  1  execute resolves head instruction
io_exe_pc  in  64  resolved instruction PC
io_exe_is_br  in  1  instruction is branch/jump
io_exe_br_type  in  2  0 plain, 1 call, 2 return
io_exe_taken  in  1  actually taken
io_exe_target  in  64  actual target when taken
io_br_info_valid  out  1  predictor update strobe
io_br_info_mispredict  out  1  prediction was wrong
io_br_info_br_pc  out  64  PC of resolved instruction
io_br_info_taken  out  1  actual direction
io_br_info_target_next_pc  out  64  actual next PC
io_br_info_br_type  out  2  copy of io_exe_br_type
io_redirect_valid  out  1  flush front end
io_redirect_pc  out  64  restart PC
io_err  out  1  sticky protocol error
io_br_cnt  out  CNT_W  resolved branches
io_mis_cnt  out  CNT_W  mispredicts

Behaviour:
- Reset (reset==0 at posedge): queue empty; head=tail=0; all outputs 0; counters 0; io_err 0.
- Queue:
  - circular, DEPTH entries, {pc, pre_valid, pre_next_pc}.
  - Pointers are log2(DEPTH)+1 bits with a wrap bit. full = indices equal and wrap bits differ; empty = pointers equal.
  - io_fetch_ready = !full & !io_redirect_valid (combinational).
  - Push occurs when io_fetch_valid & io_fetch_ready. Push while not ready is dropped silently.
- Resolve (io_exe_valid & !empty), combinational on the head entry:
  - act_next = io_exe_taken ? io_exe_target : io_exe_pc+4, 64-bit wrap.
  - pred_next = head.pre_valid ? head.pre_next_pc : head.pc+4.
  - mis = act_next != pred_next.
  - Head pops.
- Outputs are registered: 1-cycle latency after the resolve edge, each strobe high for exactly 1 cycle.
  - io_br_info_valid = io_exe_is_br | mis. A non-branch predicted taken still updates the predictor.
  - br_pc = io_exe_pc, taken = io_exe_taken & io_exe_is_br, target_next_pc = act_next.
  - io_redirect_valid = mis, io_redirect_pc = act_next.
- Mispredict: at the same edge the whole queue is cleared (tail=head=0). Any simultaneous push is discarded.
- Simultaneous push and pop without mispredict: both occur; push allowed when full only if a pop occurs the same cycle? No: ready depends only on full, so a push while full is dropped.
- io_err set (sticky until reset), with no other effect, on either:
  - io_exe_valid with queue empty (no pop, no outputs);
  - io_exe_pc != head.pc. Pop and resolution still proceed using io_exe_pc.
- Counters:
  - io_br_cnt +1 per resolve with io_exe_is_br.
  - io_mis_cnt +1 per resolve with mis.
  - Both saturate at all-ones; they update on the same edge as the registered outputs.
- Reset asserted mid-operation overrides everything that cycle, including a pending pop or push.

Test Plan:
- Correctly predicted branch: push {0x80000000, pre_valid=1, 0x80000100}; exe pc 0x80000000, is_br=1, taken=1, target 0x80000100.
  -> next cycle br_info_valid=1, mispredict=0, target 0x80000100, no redirect, br_cnt=1.
- Wrong direction: push {0x1000, pre_valid=1, 0x2000}; exe taken=0.
  -> mispredict=1, redirect_pc=0x1004, queue empty, mis_cnt=1.
- Fill and flush: push 4 entries -> fetch_ready=0; fifth push dropped. Resolve first with mispredict while pushing -> all entries and the new push discarded; fetch_ready low for the redirect cycle, then 1.
- Non-branch false prediction: push {0x3000, 1, 0x3800}; exe is_br=0.
  -> br_info_valid=1, taken=0, target 0x3004, redirect 0x3004, br_cnt unchanged.
- Errors: exe_valid on empty -> io_err=1, no strobes. After reset, exe pc 0x10 vs head 0x14 -> io_err=1, head still pops.
- Pointer wrap: 10 push/pop pairs, one per cycle, all correct -> no error, br_cnt=10, no redirect.
